// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared types and constants for the program-counter sequencer:
//   FSM state encoding, next-PC select codes, default reset/exception
//   targets and the 16-bit carry-lookahead adder used for PC+2.
package pc_sequencer_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_INC   = 3'd1,
    SEL_EXC   = 3'd2,
    SEL_EPC   = 3'd3,
    SEL_REDIR = 3'd4
  } sel_e;

  localparam logic [15:0] DEF_RESET_PC   = 16'h0000;
  localparam logic [15:0] DEF_EXC_VECTOR = 16'h0002;

  // 16-bit carry-lookahead adder, carry-in 0, carry-out discarded.
  // Four 4-bit groups; group carries are resolved by lookahead, bits
  // inside a group ripple from the group carry.
  function automatic logic [15:0] cla16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] g, p, c;
    logic [2:0]  gg, pp;
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 3; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pp[k] = &p[4*k +: 4];
    end
    c     = '0;
    c[4]  = gg[0] | (pp[0] & c[0]);
    c[8]  = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
    c[12] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
          | (pp[2] & pp[1] & pp[0] & c[0]);
    for (int i = 1; i < 16; i++) begin
      if ((i % 4) != 0) c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    return p ^ c;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Control/status bundle between the core pipeline and the PC sequencer.
//   Pipeline -> sequencer: stall, redirect_valid, redirect_pc, siic, rti, halt.
//   Sequencer -> pipeline: pc, pc_inc, epc, fetch_valid, halted.
//   master = pipeline side, slave = sequencer side.
interface pc_sequencer_if;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        siic;
  logic        rti;
  logic        halt;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] epc;
  logic        fetch_valid;
  logic        halted;

  modport master (
    output stall, redirect_valid, redirect_pc, siic, rti, halt,
    input  pc, pc_inc, epc, fetch_valid, halted
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc, siic, rti, halt,
    output pc, pc_inc, epc, fetch_valid, halted
  );
endinterface

// File: rtl/pc_sequencer_next_sel.sv
// pc_next_sel
//   Combinational next-PC selection: priority encoder over the commit
//   events followed by a 5:1 mux of candidate PCs.
//   Inputs : run_i (FSM in RUN), event strobes, stall, redirect target,
//            current pc, pc+2 and saved epc.
//   Outputs: pc_next_o (value for the PC register), epc_we_o (load epc
//            with pc+2 this edge).
module pc_next_sel
  import pc_sequencer_pkg::*;
#(
  parameter logic [15:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        run_i,
  input  logic        halt_i,
  input  logic        siic_i,
  input  logic        rti_i,
  input  logic        redirect_valid_i,
  input  logic        stall_i,
  input  logic [15:0] redirect_pc_i,
  input  logic [15:0] pc_i,
  input  logic [15:0] pc_inc_i,
  input  logic [15:0] epc_i,
  output logic [15:0] pc_next_o,
  output logic        epc_we_o
);

  sel_e sel;

  // Control-flow events outrank stall; halt outranks everything.
  always_comb begin
    sel = SEL_HOLD;
    if (!run_i || halt_i)     sel = SEL_HOLD;
    else if (siic_i)          sel = SEL_EXC;
    else if (rti_i)           sel = SEL_EPC;
    else if (redirect_valid_i) sel = SEL_REDIR;
    else if (stall_i)         sel = SEL_HOLD;
    else                      sel = SEL_INC;
  end

  always_comb begin
    pc_next_o = pc_i;
    case (sel)
      SEL_INC:   pc_next_o = pc_inc_i;
      SEL_EXC:   pc_next_o = EXC_VECTOR;
      SEL_EPC:   pc_next_o = epc_i;
      SEL_REDIR: pc_next_o = {redirect_pc_i[15:1], 1'b0};
      default:   pc_next_o = pc_i;
    endcase
  end

  assign epc_we_o = (sel == SEL_EXC);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the 16-bit architectural PC at the head of fetch. Sequences
//   PC+2, branch/jump redirect, SIIC vector and RTI return; holds on
//   stall; freezes in HALTED until reset.
//   Ports: clk, rst (synchronous, active high), bus (pc_sequencer_if.slave).
//
//   state     | meaning
//   ST_RUN    | normal sequencing
//   ST_HALTED | pc/epc frozen, all inputs but rst ignored
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [15:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] epc_q, epc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        halted_q, halted_d;
  logic [15:0] pc_inc;
  logic        epc_we;

  assign pc_inc = cla16(pc_q, 16'h0002);

  pc_next_sel #(.EXC_VECTOR(EXC_VECTOR)) u_next_sel (
    .run_i            (state_q == ST_RUN),
    .halt_i           (bus.halt),
    .siic_i           (bus.siic),
    .rti_i            (bus.rti),
    .redirect_valid_i (bus.redirect_valid),
    .stall_i          (bus.stall),
    .redirect_pc_i    (bus.redirect_pc),
    .pc_i             (pc_q),
    .pc_inc_i         (pc_inc),
    .epc_i            (epc_q),
    .pc_next_o        (pc_d),
    .epc_we_o         (epc_we)
  );

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    if (epc_we) epc_d = pc_inc;
    if (state_q == ST_RUN && bus.halt) state_d = ST_HALTED;
    halted_d      = (state_d == ST_HALTED);
    fetch_valid_d = (state_d == ST_RUN) && !bus.stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      epc_q         <= 16'h0000;
      fetch_valid_q <= 1'b1;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_inc      = pc_inc;
  assign bus.epc         = epc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed vector table, a hand-written nested-SIIC sequence, then
//   randomized traffic checked against a behavioural model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst, stall, rv;
    logic [15:0] rpc;
    logic        siic, rti, halt;
    logic [15:0] e_pc, e_epc;
    logic        e_fv, e_h;
  } vec_t;

  vec_t vecs[$];

  // model state for the random phase
  logic [15:0] m_pc, m_epc;
  logic        m_fv, m_h;

  function automatic vec_t mk(input logic r, st, rv, input logic [15:0] rpc,
                              input logic si, rt, ht, input logic [15:0] epc_x,
                              input logic [15:0] eepc, input logic efv, eh);
    vec_t v;
    v.rst = r; v.stall = st; v.rv = rv; v.rpc = rpc;
    v.siic = si; v.rti = rt; v.halt = ht;
    v.e_pc = epc_x; v.e_epc = eepc; v.e_fv = efv; v.e_h = eh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, st, rv, input logic [15:0] rpc,
                       input logic si, rt, ht);
    rst = r; bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    bus.siic = si; bus.rti = rt; bus.halt = ht;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    drive(v.rst, v.stall, v.rv, v.rpc, v.siic, v.rti, v.halt);
    @(posedge clk);
    #1;
    chk({tag, " pc"},          bus.pc, v.e_pc);
    chk({tag, " pc_inc"},      bus.pc_inc, v.e_pc + 16'd2);
    chk({tag, " epc"},         bus.epc, v.e_epc);
    chk({tag, " fetch_valid"}, {15'd0, bus.fetch_valid}, {15'd0, v.e_fv});
    chk({tag, " halted"},      {15'd0, bus.halted}, {15'd0, v.e_h});
  endtask

  // Reference: one clock of the architectural rules.
  task automatic model_step(input logic r, st, rv, input logic [15:0] rpc,
                            input logic si, rt, ht);
    if (r) begin
      m_pc = 16'h0000; m_epc = 16'h0000; m_h = 1'b0; m_fv = 1'b1;
    end else if (m_h) begin
      m_fv = 1'b0;
    end else if (ht) begin
      m_h = 1'b1; m_fv = 1'b0;
    end else begin
      if (si) begin
        m_epc = m_pc + 16'd2;
        m_pc  = 16'h0002;
      end else if (rt)     m_pc = m_epc;
      else if (rv)         m_pc = rpc & 16'hFFFE;
      else if (!st)        m_pc = m_pc + 16'd2;
      m_fv = !st;
    end
  endtask

  initial begin
    drive(1'b1, 0, 0, 16'h0, 0, 0, 0);

    //            rst st rv rpc      si rt ht  pc       epc      fv h
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0002, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0004, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0006, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0008, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0011, 0, 0, 0, 16'h0010, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0041, 0, 0, 0, 16'h0040, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 0, 0, 0, 16'h0100, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0002, 16'h0102, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0004, 16'h0102, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0102, 16'h0102, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0104, 16'h0102, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0002, 16'h0106, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'hFFFC, 0, 0, 0, 16'hFFFC, 16'h0106, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'hFFFE, 16'h0106, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0106, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0020, 0, 0, 0, 16'h0020, 16'h0106, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0500, 1, 0, 1, 16'h0020, 16'h0106, 0, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0700, 0, 0, 0, 16'h0020, 16'h0106, 0, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0020, 16'h0106, 0, 1));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0300, 0, 0, 0, 16'h0300, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0002, 16'h0302, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0300, 0, 0, 0, 16'h0300, 16'h0302, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0300, 16'h0302, 0, 0));
    vecs.push_back(mk(1, 1, 1, 16'h0500, 0, 0, 0, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0002, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 1, 0));

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // nested SIIC: second exception overwrites epc, no stack
    run_vec(mk(0, 0, 1, 16'h1234, 0, 0, 0, 16'h1234, 16'h0000, 1, 0), "nest0");
    run_vec(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0002, 16'h1236, 1, 0), "nest1");
    run_vec(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0004, 16'h1236, 1, 0), "nest2");
    run_vec(mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0002, 16'h0006, 0, 0), "nest3");
    run_vec(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0006, 16'h0006, 1, 0), "nest4");

    // randomized traffic against the model
    drive(1'b1, 0, 0, 16'h0, 0, 0, 0);
    model_step(1'b1, 0, 0, 16'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 3000; n++) begin
      logic r, st, rv, si, rt, ht;
      logic [15:0] rpc;
      r   = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 3) == 0);
      si  = ($urandom_range(0, 7) == 0);
      rt  = ($urandom_range(0, 7) == 0);
      ht  = ($urandom_range(0, 59) == 0);
      rpc = 16'($urandom);
      drive(r, st, rv, rpc, si, rt, ht);
      model_step(r, st, rv, rpc, si, rt, ht);
      @(posedge clk);
      #1;
      chk("rnd pc", bus.pc, m_pc);
      chk("rnd pc_inc", bus.pc_inc, m_pc + 16'd2);
      chk("rnd epc", bus.epc, m_epc);
      chk("rnd fetch_valid", {15'd0, bus.fetch_valid}, {15'd0, m_fv});
      chk("rnd halted", {15'd0, bus.halted}, {15'd0, m_h});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural 16-bit program counter of the pipelined core and sequences it every cycle.
- Selects next PC from: sequential PC+2, branch/jump redirect, SIIC exception vector, RTI return (EPC). Handles stall hold and halt.
- Sits at the head of the fetch stage. Drives instruction-memory address and PC+2 to decode for link/branch computation.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- EXC_VECTOR, 16'h0002, target PC on SIIC.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit hold request; PC and state hold.
- redirect_valid  in  1  resolved branch/jump taken this cycle.
- redirect_pc  in  16  branch/jump target; bit 0 forced to 0 on load.
- siic  in  1  SIIC instruction commits this cycle.
- rti  in  1  RTI instruction commits this cycle.
- halt  in  1  HALT instruction commits this cycle.
- pc  out  16  current PC (registered); instruction-memory address.
- pc_inc  out  16  pc + 2, combinational, modulo 2^16.
- epc  out  16  saved exception return PC (registered).
- fetch_valid  out  1  registered; 1 when state RUN and not stalled.
- halted  out  1  registered; 1 in state HALTED.

Behaviour:
- Reset (rst=1 at edge, overrides everything, including mid-stall or HALTED): pc=RESET_PC, epc=16'h0000, state=RUN, halted=0, fetch_valid=1 from the cycle after reset deasserts.
- FSM states:
  - RUN: normal sequencing.
  - HALTED: pc, epc frozen. All inputs except rst ignored. Exit only via rst.
- RUN next-PC priority, highest first:
  1. halt: pc holds, next state HALTED.
  2. siic: epc <= pc_inc; pc <= EXC_VECTOR.
  3. rti: pc <= epc.
  4. redirect_valid: pc <= {redirect_pc[15:1],1'b0}.
  5. stall: pc holds.
  6. Otherwise: pc <= pc_inc.
- Control-flow events (1-4) override stall in the same cycle. Flush is the pipeline's job, not this block's.
- Latency: each selected value appears on pc exactly one cycle after the qualifying edge. No bubbles are inserted internally.
- Wrap-around: pc=16'hFFFE, sequential -> 16'h0000. pc_inc at 16'hFFFE = 16'h0000. No carry flag.
- Nested SIIC (siic while already in handler): epc overwritten with new pc_inc. No stack.
- siic and rti together: siic wins; epc updated, rti dropped.
- rti with no prior siic: pc <= epc (reset value 0). Legal.
- fetch_valid = 0 while stall=1 in RUN, and always 0 in HALTED. halted asserts the cycle after the halt edge and stays asserted.
- Only pc, epc, state, fetch_valid and halted are registered. No latches.

Decomposition:
- Shared package holds:
  - state encoding (ST_RUN, ST_HALTED, 1-bit);
  - next-PC select codes (SEL_HOLD, SEL_INC, SEL_EXC, SEL_EPC, SEL_REDIR);
  - default RESET_PC and EXC_VECTOR constants.
- PC+2 uses the team's existing 16-bit carry-lookahead adder with constant operand 2.
- One sub-module, pc_next_sel: combinational priority encoder plus 16-bit 5:1 mux producing next pc and epc write-enable. Keep the FSM and registers in pc_sequencer.

Test Plan:
- Reset then 4 idle cycles -> pc sequence 0000,0002,0004,0006; fetch_valid=1; halted=0.
- pc=0010, stall=1 for 3 cycles, then redirect_valid=1 with redirect_pc=0041 while stall still 1 -> pc holds 0010 for 3 cycles, then 0040.
- pc=0100, siic=1 -> next pc=0002, epc=0102. Later rti=1 -> pc=0102. Then siic and rti together at pc=0104 -> pc=0002, epc=0106.
- pc=FFFC, no events -> FFFE, then 0000. pc_inc at FFFE reads 0000.
- pc=0020, halt=1 with redirect_valid=1 and siic=1 -> pc stays 0020, epc unchanged, halted=1 next cycle. Further redirects ignored. rst=1 -> pc=0000, halted=0.
- rst asserted mid-stall at pc=0300 with redirect pending -> pc=0000, epc=0000 after that edge.
